// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues a request-to-send, then shifts out one command
// byte plus odd parity and stop bit on the device's clock. It finishes by
// checking the device acknowledge, and aborts if the device stops clocking.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err_ack,
    output logic       err_timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             clk_s1;
    logic             clk_s2;
    logic             clk_prev;
    logic             data_s1;
    logic             data_s2;
    logic             fall;

    logic [7:0]       din_latched;
    logic             parity;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       edge_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             accept;
    logic             ack_edge;
    logic             timeout_hit;

    // Two-flop synchronizers for both pins, plus the previous synced clock for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and pin drive; pin drive follows the state and edge count only.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        ack_edge    = 1'b0;
        timeout_hit = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    state_next = RTS;
                end
            end
            RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_next  = XFER;
            end
            XFER: begin
                case (edge_cnt)
                    4'd0:    ps2_data_oe = 1'b1;
                    4'd1, 4'd2, 4'd3, 4'd4,
                    4'd5, 4'd6, 4'd7, 4'd8:
                             ps2_data_oe = ~din_latched[3'(edge_cnt - 4'd1)];
                    4'd9:    ps2_data_oe = ~parity;
                    default: ps2_data_oe = 1'b0;
                endcase
                if (fall && (edge_cnt == 4'd10)) begin
                    ack_edge   = 1'b1;
                    state_next = FINISH;
                end else if (!fall && (tmo_cnt == TMO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte latch, phase counters and the registered one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_latched <= '0;
            parity      <= 1'b0;
            inh_cnt     <= '0;
            edge_cnt    <= '0;
            tmo_cnt     <= '0;
            done        <= 1'b0;
            err_ack     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done        <= ack_edge & ~data_s2;
            err_ack     <= ack_edge & data_s2;
            err_timeout <= timeout_hit;

            if (accept) begin
                din_latched <= din;
                parity      <= ~^din;
                inh_cnt     <= '0;
            end

            if (state == INHIBIT) begin
                inh_cnt <= inh_cnt + 1'b1;
            end

            if (state == RTS) begin
                edge_cnt <= '0;
                tmo_cnt  <= '0;
            end

            if (state == XFER) begin
                if (fall) begin
                    edge_cnt <= edge_cnt + 4'd1;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt  <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus with a simple device
// model that clocks the host's frame out and optionally acknowledges.
module tb_ps2_host_tx;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err_ack;
    logic       err_timeout;

    logic       dev_clk;
    logic       dev_data_low;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    int tmo_cnt = 0;
    int both_cnt = 0;
    int busy_bad = 0;
    int clk_oe_cycles = 0;
    logic done_d = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err_ack    (err_ack),
        .err_timeout(err_timeout)
    );

    // Open-drain bus: a line is high only when nobody pulls it low.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err_ack) ack_cnt++;
        if (err_timeout) tmo_cnt++;
        if (done && err_ack) both_cnt++;
        if (done && !busy) busy_bad++;
        if (done_d && busy) busy_bad++;
        if (ps2_clk_oe) clk_oe_cycles++;
        done_d = done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] value);
        @(negedge clk);
        din   = value;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Device: waits for the request, clocks n_edges falls, samples data
    // before each rising clock, optionally acks. Can inject a start or a
    // reset pulse partway through a given low phase.
    task automatic dev_xfer(input int n_edges, input bit ack,
                            input int inj_edge, input logic [7:0] inj_din,
                            input int rst_edge,
                            output logic [9:0] bits, output int last_fall);
        int w;
        bits      = '0;
        last_fall = 0;
        w         = 0;
        while (!(busy && !ps2_clk_oe && ps2_data_oe) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rts_seen", 32'(w < 100), 1);
        check("start_bit", 32'(ps2_data_in), 0);
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk   = 1'b0;
            last_fall = cyc;
            for (int c = 0; c < HALF; c++) begin
                if (k == inj_edge && c == 2) begin
                    start = 1'b1;
                    din   = inj_din;
                end else begin
                    start = 1'b0;
                end
                if (k == rst_edge && c == HALF / 2) begin
                    check("pre_reset_data_oe", 32'(ps2_data_oe), 1);
                    #2 reset = 1'b1;
                    #1;
                    check("reset_clk_oe", 32'(ps2_clk_oe), 0);
                    check("reset_data_oe", 32'(ps2_data_oe), 0);
                    check("reset_busy", 32'(busy), 0);
                    #1 reset = 1'b0;
                end
                @(negedge clk);
            end
            if (k <= 10) bits[k-1] = ps2_data_in;
            dev_clk = 1'b1;
            if (k == 10 && ack) dev_data_low = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
        start        = 1'b0;
    endtask

    initial begin
        logic [9:0] bits;
        int lf;
        int w;
        int lat;
        int d0, a0, t0, c0, b0;

        reset        = 1'b1;
        start        = 1'b0;
        din          = 8'h00;
        dev_clk      = 1'b1;
        dev_data_low = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({done, err_ack, err_timeout}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_outputs", 32'({ps2_clk_oe, ps2_data_oe, busy, done, err_ack, err_timeout}), 0);

        // Device clock edges while idle change nothing.
        d0 = done_cnt; a0 = ack_cnt; t0 = tmo_cnt;
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            repeat (6) @(negedge clk);
            check("idle_edge_low", 32'({ps2_clk_oe, ps2_data_oe, busy, done, err_ack, err_timeout}), 0);
            dev_clk = 1'b1;
            repeat (6) @(negedge clk);
            check("idle_edge_high", 32'({ps2_clk_oe, ps2_data_oe, busy}), 0);
        end
        check("idle_no_pulses", 32'((done_cnt - d0) + (ack_cnt - a0) + (tmo_cnt - t0)), 0);

        // 0xED with acknowledge: 0xED has six ones, so odd parity bit is 1.
        d0 = done_cnt; a0 = ack_cnt; c0 = clk_oe_cycles; b0 = busy_bad;
        pulse_start(8'hED);
        dev_xfer(11, 1'b1, 0, 8'h00, 0, bits, lf);
        repeat (5) @(negedge clk);
        check("ed_data", 32'(bits[7:0]), 32'hED);
        check("ed_parity", 32'(bits[8]), 1);
        check("ed_stop", 32'(bits[9]), 1);
        check("ed_clk_oe_cycles", 32'(clk_oe_cycles - c0), 9);
        check("ed_done", 32'(done_cnt - d0), 1);
        check("ed_no_err_ack", 32'(ack_cnt - a0), 0);
        check("ed_busy_after_done", 32'(busy_bad - b0), 0);
        check("ed_idle", 32'({ps2_clk_oe, ps2_data_oe, busy}), 0);

        // 0x00 without acknowledge: parity 1, err_ack only.
        d0 = done_cnt; a0 = ack_cnt;
        pulse_start(8'h00);
        dev_xfer(11, 1'b0, 0, 8'h00, 0, bits, lf);
        repeat (5) @(negedge clk);
        check("z_data", 32'(bits[7:0]), 0);
        check("z_parity", 32'(bits[8]), 1);
        check("z_err_ack", 32'(ack_cnt - a0), 1);
        check("z_no_done", 32'(done_cnt - d0), 0);

        // Device stops after edge 5. Latency from the pin falling: two
        // synchronizer stages, one edge-register stage, then 64 idle cycles.
        d0 = done_cnt; a0 = ack_cnt; t0 = tmo_cnt;
        pulse_start(8'hA5);
        dev_xfer(5, 1'b0, 0, 8'h00, 0, bits, lf);
        check("to_bits", 32'(bits[4:0]), 32'h05);
        w = 0;
        while (!err_timeout && w < 200) begin
            @(negedge clk);
            w++;
        end
        lat = cyc - lf;
        check("to_seen", 32'(w < 200), 1);
        check("to_latency", 32'(lat), 67);
        check("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("to_idle", 32'(busy), 0);
        @(negedge clk);
        check("to_one_cycle", 32'(err_timeout), 0);
        repeat (3) @(negedge clk);
        check("to_count", 32'(tmo_cnt - t0), 1);
        check("to_no_other", 32'((done_cnt - d0) + (ack_cnt - a0)), 0);

        // Start with 0x00 during edge 3 of a 0xF4 transfer is ignored. 0xF4 parity 0.
        d0 = done_cnt;
        pulse_start(8'hF4);
        dev_xfer(11, 1'b1, 3, 8'h00, 0, bits, lf);
        repeat (5) @(negedge clk);
        check("f4_data", 32'(bits[7:0]), 32'hF4);
        check("f4_parity", 32'(bits[8]), 0);
        check("f4_stop", 32'(bits[9]), 1);
        check("f4_done", 32'(done_cnt - d0), 1);

        // Reset during edge 6 of 0x5A (bit 5 is 0, so data is driven low then).
        d0 = done_cnt; a0 = ack_cnt; t0 = tmo_cnt;
        pulse_start(8'h5A);
        dev_xfer(6, 1'b0, 0, 8'h00, 6, bits, lf);
        repeat (80) @(negedge clk);
        check("rst_mid_pulses", 32'((done_cnt - d0) + (ack_cnt - a0) + (tmo_cnt - t0)), 0);
        check("rst_mid_idle", 32'({ps2_clk_oe, ps2_data_oe, busy}), 0);

        // Following 0xFF transfer completes; eight ones gives parity 1.
        d0 = done_cnt;
        pulse_start(8'hFF);
        dev_xfer(11, 1'b1, 0, 8'h00, 0, bits, lf);
        repeat (5) @(negedge clk);
        check("ff_data", 32'(bits[7:0]), 32'hFF);
        check("ff_parity", 32'(bits[8]), 1);
        check("ff_done", 32'(done_cnt - d0), 1);

        check("never_done_and_err_ack", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clk cycles ps2_clk is held low before a request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum clk cycles between device falling edges before the transfer aborts.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to send din.
REQ-006 SHALL have port din, input, 8: command byte, latched on an accepted start.
REQ-007 SHALL have port ps2_clk_in, input, 1: PS/2 clock pin, asynchronous.
REQ-008 SHALL have port ps2_data_in, input, 1: PS/2 data pin, asynchronous.
REQ-009 SHALL have port ps2_clk_oe, output, 1: 1 = drive the clock pin low; 0 = release it.
REQ-010 SHALL have port ps2_data_oe, output, 1: 1 = drive the data pin low; 0 = release it.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the device acknowledges.
REQ-013 SHALL have port err_ack, output, 1: one-cycle pulse when no acknowledge is seen.
REQ-014 SHALL have port err_timeout, output, 1: one-cycle pulse on a timeout abort.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in each through a 2-flop synchronizer; falling edge = previous synced clk 1 and current synced clk 0.
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, XFER, FINISH.
REQ-017 IDLE: both oe = 0; start = 1 SHALL latch din and compute parity = XNOR-reduce(din) (odd parity), then go to INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe = 1 and ps2_data_oe = 0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-019 RTS: ps2_clk_oe = 1 and ps2_data_oe = 1 (start bit) for exactly 1 cycle, then go to XFER.
REQ-020 XFER: ps2_clk_oe = 0 and ps2_data_oe held at 1 until the first falling edge.
REQ-021 XFER, 4-bit edge counter, edges 1-8: ps2_data_oe = NOT din[k-1], LSB first.
REQ-022 XFER, edge 9: ps2_data_oe = NOT parity.
REQ-023 XFER, edge 10: ps2_data_oe = 0 (stop bit, line released).
REQ-024 XFER, edge 11: sample synced data; 0 → done pulse, 1 → err_ack pulse; then go to FINISH.
REQ-025 ps2_data_oe SHALL update no later than 4 clk cycles after a ps2_clk_in falling transition.
REQ-026 FINISH SHALL last 1 cycle with both oe = 0 and SHALL then go to IDLE; done and err_ack SHALL never assert together.
REQ-027 Timeout counter SHALL clear on entry to XFER and on each falling edge; reaching TIMEOUT_CYCLES SHALL set both oe = 0, pulse err_timeout and go to IDLE.
REQ-028 start while busy SHALL be ignored, with no effect on din_latched or the transfer.
REQ-029 A start in the same cycle as a FINISH → IDLE transition SHALL be ignored; start is accepted only while in IDLE.
REQ-030 Falling edges seen in IDLE, INHIBIT or RTS SHALL be ignored (device-to-host traffic is not this block's concern).

Reset
REQ-031 reset SHALL force IDLE; edge and timeout counters to 0; ps2_clk_oe, ps2_data_oe, busy, done, err_ack, err_timeout to 0; synchronizer flops to 1.
REQ-032 reset asserted mid-transfer SHALL release both lines immediately (asynchronously), with no done or error pulse.

Verification (bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64; device model clocks at ≥20 clk per half period)
REQ-033 start with din=0xED; device clocks 11 edges and drives data low at edge 11 → clk_oe high exactly 9 cycles (8 INHIBIT + 1 RTS); device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy falls the next cycle.
REQ-034 din=0x00, device leaves data high at edge 11 → parity bit 1 sent; err_ack pulses once; done stays 0.
REQ-035 Device stops after edge 5 → err_timeout pulses 64 cycles after edge 5 detection; both oe = 0; state IDLE.
REQ-036 din=0xF4 transfer; second start with din=0x00 at edge 3 → byte seen by device remains 0xF4.
REQ-037 reset pulsed during edge 6 → both oe = 0 in the same cycle; no pulses; a following start with din=0xFF completes with parity bit 1.
REQ-038 Falling edges on ps2_clk_in while IDLE → no output change; busy stays 0.
